// File: rtl/ui_pkg.sv
// rtl/ui_pkg.sv - shared FSM states and step-pulse bundle for the button repeat controller
package ui_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic ce;
  } step_pulse_t;

  localparam step_pulse_t PULSE_NONE = '0;

  // One step in direction dir (0=up, 1=down); ce always accompanies a step.
  function automatic step_pulse_t make_pulse(input logic dir);
    step_pulse_t p;
    p.up   = ~dir;
    p.down = dir;
    p.ce   = 1'b1;
    return p;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer plus consecutive-sample debouncer for one button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic btn_raw,
  output logic btn_level
);

  localparam int CW_RAW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] stable_cnt;

  // Two-flop synchronizer; the only place the raw button is sampled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level once the synchronized input has differed for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stable_cnt <= '0;
      btn_level  <= 1'b0;
    end else if (sync_q2 == btn_level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      stable_cnt <= '0;
      btn_level  <= sync_q2;
    end else begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/button_repeat_ctrl.sv
// rtl/button_repeat_ctrl.sv - debounced up/down buttons with press-and-hold auto-repeat step pulses
module button_repeat_ctrl
  import ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_up,
  input  logic i_btn_down,
  output logic o_count_up,
  output logic o_count_down,
  output logic o_ce,
  output logic o_held
);

  localparam int TMAX   = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int TW_RAW = $clog2(TMAX);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

  logic          lvl_up;
  logic          lvl_down;
  rep_state_t    state;
  logic          dir;
  logic [TW-1:0] timer;
  step_pulse_t   pulse_q;
  logic          held_q;
  logic          latched_lvl;
  logic          other_lvl;
  logic          abort_hold;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .btn_raw  (i_btn_up),
    .btn_level(lvl_up)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .btn_raw  (i_btn_down),
    .btn_level(lvl_down)
  );

  // A hold ends when the latched button is released or the opposite button joins in.
  assign latched_lvl = dir ? lvl_down : lvl_up;
  assign other_lvl   = dir ? lvl_up   : lvl_down;
  assign abort_hold  = ~latched_lvl | other_lvl;

  // Press/hold/repeat sequencer with registered pulse and held outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      dir     <= 1'b0;
      timer   <= '0;
      pulse_q <= PULSE_NONE;
      held_q  <= 1'b0;
    end else begin
      pulse_q <= PULSE_NONE;
      case (state)
        ST_IDLE: begin
          if (lvl_up ^ lvl_down) begin
            dir     <= lvl_down;
            pulse_q <= make_pulse(lvl_down);
            timer   <= DELAY_LOAD;
            state   <= ST_DELAY;
            held_q  <= 1'b1;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (abort_hold) begin
            state  <= ST_IDLE;
            held_q <= 1'b0;
          end else if (timer == '0) begin
            pulse_q <= make_pulse(dir);
            timer   <= PERIOD_LOAD;
            state   <= ST_REPEAT;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_count_up   = pulse_q.up;
  assign o_count_down = pulse_q.down;
  assign o_ce         = pulse_q.ce;
  assign o_held       = held_q;

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// tb/tb_button_repeat_ctrl.sv - self-checking bench for button_repeat_ctrl with behavioural model
module tb_button_repeat_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic i_clk;
  logic i_reset;
  logic i_btn_up;
  logic i_btn_down;
  logic o_count_up;
  logic o_count_down;
  logic o_ce;
  logic o_held;

  int errors = 0;
  int checks = 0;

  // model state: edge index since reset, hold start edge, debounced levels, raw history
  int n;
  bit m_idle;
  bit m_dir;
  int m_start;
  bit lv_u;
  bit lv_d;
  bit h_u [16];
  bit h_d [16];

  int up_log[$];
  int dn_log[$];
  int held_cnt;
  bit held_at [256];

  button_repeat_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_btn_up    (i_btn_up),
    .i_btn_down  (i_btn_down),
    .o_count_up  (o_count_up),
    .o_count_down(o_count_down),
    .o_ce        (o_ce),
    .o_held      (o_held)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    n       = 0;
    m_idle  = 1'b1;
    m_dir   = 1'b0;
    m_start = 0;
    lv_u    = 1'b0;
    lv_d    = 1'b0;
    for (int k = 0; k < 16; k++) begin
      h_u[k] = 1'b0;
      h_d[k] = 1'b0;
    end
  endtask

  // debouncer's view of the button at edge m: the raw value two edges earlier, 0 just after reset
  function automatic bit dsamp(input bit which, input int m);
    if (m < 3) return 1'b0;
    return which ? h_d[(m - 2) % 16] : h_u[(m - 2) % 16];
  endfunction

  function automatic bit window_all(input bit which, input bit value);
    for (int k = 0; k < DEB; k++)
      if (dsamp(which, n - k) != value) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(output bit e_up, output bit e_dn, output bit e_held);
    bit pulse;
    bit lat;
    bit oth;
    int el;
    pulse = 1'b0;
    n++;
    h_u[n % 16] = i_btn_up;
    h_d[n % 16] = i_btn_down;
    if (m_idle) begin
      if (lv_u != lv_d) begin
        m_idle  = 1'b0;
        m_dir   = lv_d;
        m_start = n;
        pulse   = 1'b1;
      end
    end else begin
      lat = m_dir ? lv_d : lv_u;
      oth = m_dir ? lv_u : lv_d;
      if (!lat || oth) begin
        m_idle = 1'b1;
      end else begin
        el = n - m_start;
        if (el == RD || (el > RD && (el - RD) % RP == 0)) pulse = 1'b1;
      end
    end
    e_up   = pulse && !m_dir;
    e_dn   = pulse && m_dir;
    e_held = !m_idle;
    if (window_all(1'b0, 1'b1)) lv_u = 1'b1;
    else if (window_all(1'b0, 1'b0)) lv_u = 1'b0;
    if (window_all(1'b1, 1'b1)) lv_d = 1'b1;
    else if (window_all(1'b1, 1'b0)) lv_d = 1'b0;
  endtask

  // compare process: advance the model for the edge just taken and check every output
  initial begin
    bit eu, ed, eh;
    logic [3:0] got;
    logic [3:0] exp;
    model_reset();
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        model_reset();
        exp = 4'b0000;
      end else begin
        model_step(eu, ed, eh);
        exp = {eu, ed, eu | ed, eh};
      end
      got = {o_count_up, o_count_down, o_ce, o_held};
      check($sformatf("outputs{up,dn,ce,held}@edge%0d", n), int'(got), int'(exp));
      if (!i_reset) begin
        if (o_count_up) up_log.push_back(n);
        if (o_count_down) dn_log.push_back(n);
        if (o_held) held_cnt++;
        if (n < 256) held_at[n] = o_held;
      end
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(negedge i_clk);
      #1;
    end
  endtask

  // reset for two cycles, then present the buttons so the next edge is edge 1
  task automatic start(input logic u, input logic d);
    @(negedge i_clk);
    #1;
    i_reset    = 1'b1;
    i_btn_up   = 1'b0;
    i_btn_down = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    i_reset    = 1'b0;
    i_btn_up   = u;
    i_btn_down = d;
    up_log.delete();
    dn_log.delete();
    held_cnt = 0;
  endtask

  function automatic int count_in(input int q[$], input int lo, input int hi);
    int c;
    c = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] <= hi) c++;
    return c;
  endfunction

  initial begin
    int exp27 [6];
    int q27[$];
    int mode;
    int thr;
    exp27 = '{7, 17, 20, 23, 26, 29};
    i_reset    = 1'b1;
    i_btn_up   = 1'b0;
    i_btn_down = 1'b0;
    #3;
    check("reset_outputs", int'({o_count_up, o_count_down, o_ce, o_held}), 0);
    step(3);

    // clean up press held 30 cycles
    start(1'b1, 1'b0);
    step(30);
    i_btn_up = 1'b0;
    step(20);
    q27.delete();
    foreach (up_log[i]) if (up_log[i] <= 30) q27.push_back(up_log[i]);
    check("hold_up_pulse_count", q27.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < q27.size()) check($sformatf("hold_up_pulse%0d_edge", k), q27[k], exp27[k]);
    check("hold_up_no_down", dn_log.size(), 0);

    // bouncing up button
    start(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      i_btn_up = (i % 2 == 0);
      step(2);
    end
    i_btn_up = 1'b0;
    step(20);
    check("bounce_no_pulse", up_log.size() + dn_log.size(), 0);
    check("bounce_never_held", held_cnt, 0);

    // both buttons together
    start(1'b1, 1'b1);
    step(30);
    i_btn_up   = 1'b0;
    i_btn_down = 1'b0;
    step(15);
    check("both_no_pulse", up_log.size() + dn_log.size(), 0);
    check("both_never_held", held_cnt, 0);

    // down held into repeat, then up joins, then down released
    start(1'b0, 1'b1);
    step(24);
    i_btn_up = 1'b1;
    step(25);
    i_btn_down = 1'b0;
    step(15);
    check("conflict_last_down_edge", (dn_log.size() > 0) ? dn_log[$] : -1, 29);
    check("conflict_held_edge30", int'(held_at[30]), 1);
    check("conflict_held_edge31", int'(held_at[31]), 0);
    check("conflict_quiet_window", count_in(up_log, 31, 55) + count_in(dn_log, 31, 55), 0);
    check("conflict_first_up_edge", (up_log.size() > 0) ? up_log[0] : -1, 56);

    // reset during repeat while up stays held
    start(1'b1, 1'b0);
    step(20);
    check("prereset_pulse_high", int'(o_count_up), 1);
    #1;
    i_reset = 1'b1;
    #1;
    check("async_reset_outputs", int'({o_count_up, o_count_down, o_ce, o_held}), 0);
    repeat (2) @(negedge i_clk);
    #1;
    i_reset = 1'b0;
    up_log.delete();
    dn_log.delete();
    step(15);
    check("post_reset_first_pulse", (up_log.size() > 0) ? up_log[0] : -1, 7);

    // press exactly the debounce window, then one cycle shorter
    start(1'b1, 1'b0);
    step(DEB);
    i_btn_up = 1'b0;
    step(20);
    check("window_exact_pulses", up_log.size(), 1);
    check("window_exact_edge", (up_log.size() > 0) ? up_log[0] : -1, 7);
    start(1'b1, 1'b0);
    step(DEB - 1);
    i_btn_up = 1'b0;
    step(20);
    check("window_short_pulses", up_log.size(), 0);

    // randomized stimulus against the model
    start(1'b0, 1'b0);
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) mode = $urandom_range(0, 2);
      thr = (mode == 0) ? 2 : ((mode == 1) ? 40 : 400);
      if ($urandom_range(0, thr - 1) == 0) i_btn_up = ~i_btn_up;
      if ($urandom_range(0, thr - 1) == 0) i_btn_down = ~i_btn_down;
      i_reset = ($urandom_range(0, 799) == 0);
      step(1);
    end
    i_reset = 1'b0;
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_repeat_ctrl.md
BUTTON_REPEAT_CTRL -- requirements
Module: button_repeat_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles before a button change is accepted.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000: cycles from first pulse to first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have port i_clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have port i_reset, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port i_btn_up, input, 1: raw asynchronous up button, active-high.
REQ-007 SHALL have port i_btn_down, input, 1: raw asynchronous down button, active-high.
REQ-008 SHALL have port o_count_up, output, 1: one-cycle up-step pulse, feeds the downstream up/down counter's count-up input.
REQ-009 SHALL have port o_count_down, output, 1: one-cycle down-step pulse, feeds the counter's count-down input.
REQ-010 SHALL have port o_ce, output, 1: high exactly when o_count_up or o_count_down is high, feeds the counter's clock-enable.
REQ-011 SHALL have port o_held, output, 1: high while FSM is in DELAY or REPEAT.

Function
REQ-012 SHALL pass each raw button through a 2-flop synchronizer; no other logic samples raw inputs.
REQ-013 SHALL update each debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count from zero.
REQ-014 SHALL implement FSM states IDLE, DELAY, REPEAT with a latched direction bit dir (0=up, 1=down).
REQ-015 IDLE: exactly one debounced button high -> latch dir, pulse that direction next cycle, load timer with REPEAT_DELAY-1, go DELAY.
REQ-016 IDLE: both or neither debounced high -> stay IDLE, no pulse.
REQ-017 DELAY: timer counts down each cycle; at zero -> pulse dir, load REPEAT_PERIOD-1, go REPEAT.
REQ-018 REPEAT: at timer zero -> pulse dir, reload REPEAT_PERIOD-1, stay REPEAT.
REQ-019 DELAY/REPEAT: latched button debounced low, or other button debounced high -> IDLE next cycle, no pulse that cycle; a new press is evaluated from IDLE on the following cycle.
REQ-020 o_count_up and o_count_down SHALL be registered, one cycle wide, never simultaneously high.
REQ-021 Timer width SHALL be $clog2 of max(REPEAT_DELAY, REPEAT_PERIOD); debounce counter width $clog2(DEBOUNCE_CYCLES+1); no wrap-around permitted.
REQ-022 Latency: first pulse SHALL appear 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the first clock edge sampling a clean raw press.

Reset
REQ-023 i_reset asserted SHALL immediately clear synchronizers, debounced levels (0), counters, timer, dir, FSM (IDLE) and all outputs (0), independent of i_clk.
REQ-024 Reset mid-DELAY/REPEAT SHALL emit no pulse; a button still held after release is re-debounced and treated as a new press.

Structure
REQ-025 FSM state encodings and the pulse-output bundle SHALL live in shared package ui_pkg.
REQ-026 Synchronizer plus debounce SHALL be sub-module btn_debounce, instantiated once per button.

Verification
REQ-027 DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3; clean up press held 30 cycles -> o_count_up pulses at cycles 7, 17, 20, 23, 26, 29; o_ce identical; o_count_down stays 0.
REQ-028 Same params; up toggles every 2 cycles for 20 cycles then held low -> zero pulses, FSM stays IDLE.
REQ-029 Both buttons pressed same cycle, held 30 cycles -> no pulses, o_held=0 throughout.
REQ-030 Down held into REPEAT, up then pressed -> IDLE after up debounces, no further pulses until down released; then up pulses after 1 cycle.
REQ-031 i_reset asserted 2 cycles during REPEAT, button held -> outputs 0 asynchronously, next pulse exactly 7 cycles after reset deasserts.
REQ-032 Held press up 1 cycle shorter than debounce window -> no pulse; exactly DEBOUNCE_CYCLES -> exactly one pulse.
